// File: rtl/tlb_ctrl_pkg.sv
// Shared MMU TLB definitions: entry geometry, CP0 op encoding, packed field offsets
// and the helper that packs CP0 EntryHi/EntryLo fields into one stored entry.
package tlb_ctrl_pkg;

    localparam int unsigned TLB_ENTRY_NUM   = 16;
    localparam int unsigned TLB_ENTRY_WIDTH = 96;

    typedef logic [TLB_ENTRY_NUM*TLB_ENTRY_WIDTH-1:0] TLB_entries_t;
    typedef logic [TLB_ENTRY_WIDTH-1:0]               TLB_entry_t;
    typedef logic [3:0]                               TLB_index_t;
    typedef logic [31:0]                              Word_t;
    typedef logic                                     Bit_t;

    typedef enum logic [1:0] {
        OpTlbr  = 2'd0,
        OpTlbwi = 2'd1,
        OpTlbwr = 2'd2,
        OpTlbp  = 2'd3
    } TLB_op_t;

    localparam int unsigned VPN2_LSB = 0;
    localparam int unsigned ASID_LSB = 24;
    localparam int unsigned PFN0_LSB = 32;
    localparam int unsigned C0_LSB   = 58;
    localparam int unsigned D0_BIT   = 61;
    localparam int unsigned V0_BIT   = 62;
    localparam int unsigned G0_BIT   = 63;
    localparam int unsigned PFN1_LSB = 64;
    localparam int unsigned C1_LSB   = 90;
    localparam int unsigned D1_BIT   = 93;
    localparam int unsigned V1_BIT   = 94;
    localparam int unsigned G1_BIT   = 95;

    // Takes only the meaningful CP0 bits; every other stored bit is zero.
    function automatic TLB_entry_t pack_entry(logic [18:0] vpn2, logic [7:0] asid,
                                              logic [25:0] lo0, logic [25:0] lo1);
        TLB_entry_t e;
        Bit_t       g;
        g = lo0[0] & lo1[0];
        e = '0;
        e[VPN2_LSB +: 19] = vpn2;
        e[ASID_LSB +: 8]  = asid;
        e[PFN0_LSB +: 20] = lo0[25:6];
        e[C0_LSB +: 3]    = lo0[5:3];
        e[D0_BIT]         = lo0[2];
        e[V0_BIT]         = lo0[1];
        e[G0_BIT]         = g;
        e[PFN1_LSB +: 20] = lo1[25:6];
        e[C1_LSB +: 3]    = lo1[5:3];
        e[D1_BIT]         = lo1[2];
        e[V1_BIT]         = lo1[1];
        e[G1_BIT]         = g;
        return e;
    endfunction

    function automatic TLB_index_t first_set(logic [TLB_ENTRY_NUM-1:0] v);
        TLB_index_t idx;
        idx = '0;
        for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = TLB_index_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tlb_random.sv
// Random/Wired register pair: Random counts down each cycle from 15 to Wired, then reloads 15.
// A Wired write reloads Random in the same edge.
module tlb_random
    import tlb_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wired_we_i,
    input  logic [3:0] wired_i,
    output logic [3:0] random_o,
    output logic [3:0] wired_o
);

    localparam TLB_index_t RandomTop = 4'd15;

    TLB_index_t random_q;
    TLB_index_t wired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            random_q <= RandomTop;
            wired_q  <= '0;
        end else if (wired_we_i) begin
            random_q <= RandomTop;
            wired_q  <= wired_i;
        end else if (random_q == wired_q) begin
            random_q <= RandomTop;
        end else begin
            random_q <= random_q - 4'd1;
        end
    end

    assign random_o = random_q;
    assign wired_o  = wired_q;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB array owner and CP0 TLBR/TLBWI/TLBWR/TLBP sequencer.
// Define TLB_MCHECK_EN to build multiple-match detection for TLBP (mcheck_o).
module tlb_ctrl
    import tlb_ctrl_pkg::*;
#(
    parameter int unsigned ENTRY_NUM = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [3:0]  index_i,
    input  logic [31:0] entryhi_i,
    input  logic [31:0] entrylo0_i,
    input  logic [31:0] entrylo1_i,
    input  logic        wired_we_i,
    input  logic [3:0]  wired_i,
    output logic        done_o,
    output logic [31:0] rd_entryhi_o,
    output logic [31:0] rd_entrylo0_o,
    output logic [31:0] rd_entrylo1_o,
    output logic        probe_miss_o,
    output logic [3:0]  probe_index_o,
    output logic        mcheck_o,
    output logic [3:0]  random_o,
    output logic [3:0]  wired_o,
    output logic [TLB_ENTRY_NUM*TLB_ENTRY_WIDTH-1:0] entries_o
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StProbe1, StProbe2, StDone} state_e;

    state_e                   state_q;
    TLB_entries_t             entries_q;
    TLB_entry_t               wr_entry_q;
    TLB_entry_t               sel_entry;
    TLB_index_t               idx_q;
    logic [18:0]              key_vpn2_q;
    logic [7:0]               key_asid_q;
    logic [TLB_ENTRY_NUM-1:0] match_d;
    logic [TLB_ENTRY_NUM-1:0] match_q;
    logic                     ready_q;
    logic                     done_q;
    logic                     miss_q;
    TLB_index_t               pidx_q;
    Word_t                    rd_hi_q;
    Word_t                    rd_lo0_q;
    Word_t                    rd_lo1_q;
    TLB_index_t               random;
    logic                     unused_bits;

    tlb_random u_random (
        .clk        (clk),
        .rst_n      (rst_n),
        .wired_we_i (wired_we_i),
        .wired_i    (wired_i),
        .random_o   (random),
        .wired_o    (wired_o)
    );

    assign sel_entry = entries_q[int'(idx_q)*TLB_ENTRY_WIDTH +: TLB_ENTRY_WIDTH];

    // V is deliberately ignored: a probe must find invalid entries too.
    always_comb begin
        match_d = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            match_d[i] = (entries_q[i*TLB_ENTRY_WIDTH + VPN2_LSB +: 19] == key_vpn2_q) &&
                         ((entries_q[i*TLB_ENTRY_WIDTH + ASID_LSB +: 8] == key_asid_q) ||
                          entries_q[i*TLB_ENTRY_WIDTH + G0_BIT]);
        end
    end

`ifdef TLB_MCHECK_EN
    logic mcheck_q;

    function automatic logic [4:0] popcount(logic [TLB_ENTRY_NUM-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            entries_q  <= '0;
            wr_entry_q <= '0;
            idx_q      <= '0;
            key_vpn2_q <= '0;
            key_asid_q <= '0;
            match_q    <= '0;
            miss_q     <= 1'b0;
            pidx_q     <= '0;
            rd_hi_q    <= '0;
            rd_lo0_q   <= '0;
            rd_lo1_q   <= '0;
`ifdef TLB_MCHECK_EN
            mcheck_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && ready_q) begin
                        ready_q    <= 1'b0;
                        wr_entry_q <= pack_entry(entryhi_i[31:13], entryhi_i[7:0],
                                                 entrylo0_i[25:0], entrylo1_i[25:0]);
                        key_vpn2_q <= entryhi_i[31:13];
                        key_asid_q <= entryhi_i[7:0];
                        // TLBWR target is frozen here; later Wired writes cannot move it.
                        idx_q      <= (TLB_op_t'(req_op_i) == OpTlbwr) ? random : index_i;
                        unique case (TLB_op_t'(req_op_i))
                            OpTlbr:           state_q <= StRead;
                            OpTlbwi, OpTlbwr: state_q <= StWrite;
                            OpTlbp:           state_q <= StProbe1;
                        endcase
                    end
                end
                StWrite: begin
                    entries_q[int'(idx_q)*TLB_ENTRY_WIDTH +: TLB_ENTRY_WIDTH] <= wr_entry_q;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StRead: begin
                    rd_hi_q  <= {sel_entry[VPN2_LSB +: 19], 5'd0, sel_entry[ASID_LSB +: 8]};
                    rd_lo0_q <= {6'd0, sel_entry[PFN0_LSB +: 20], sel_entry[C0_LSB +: 3],
                                 sel_entry[D0_BIT], sel_entry[V0_BIT], sel_entry[G0_BIT]};
                    rd_lo1_q <= {6'd0, sel_entry[PFN1_LSB +: 20], sel_entry[C1_LSB +: 3],
                                 sel_entry[D1_BIT], sel_entry[V1_BIT], sel_entry[G1_BIT]};
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StProbe1: begin
                    match_q <= match_d;
                    state_q <= StProbe2;
                end
                StProbe2: begin
                    miss_q  <= (match_q == '0);
                    pidx_q  <= first_set(match_q);
`ifdef TLB_MCHECK_EN
                    mcheck_q <= (popcount(match_q) > 5'd1);
`endif
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign done_o        = done_q;
    assign rd_entryhi_o  = rd_hi_q;
    assign rd_entrylo0_o = rd_lo0_q;
    assign rd_entrylo1_o = rd_lo1_q;
    assign probe_miss_o  = miss_q;
    assign probe_index_o = pidx_q;
    assign random_o      = random;
    assign entries_o     = entries_q;
`ifdef TLB_MCHECK_EN
    assign mcheck_o      = mcheck_q;
`else
    assign mcheck_o      = 1'b0;
`endif

    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26],
                           sel_entry[23:19], sel_entry[57:52], sel_entry[89:84]};

endmodule

// File: tb/tb_tlb_ctrl.sv
// Scoreboard bench for tlb_ctrl: a field-level TLB model predicts each completion and a
// negedge monitor compares it, plus Random/Wired, whenever the DUT signals done.
module tb_tlb_ctrl;

    localparam int N = 16;
    localparam int W = 96;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [3:0]     index;
    logic [31:0]    entryhi;
    logic [31:0]    entrylo0;
    logic [31:0]    entrylo1;
    logic           wired_we;
    logic [3:0]     wired_in;
    logic           done;
    logic [31:0]    rd_hi;
    logic [31:0]    rd_lo0;
    logic [31:0]    rd_lo1;
    logic           probe_miss;
    logic [3:0]     probe_index;
    logic           mcheck;
    logic [3:0]     random_v;
    logic [3:0]     wired_v;
    logic [N*W-1:0] entries;

    tlb_ctrl #(.ENTRY_NUM(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .index_i       (index),
        .entryhi_i     (entryhi),
        .entrylo0_i    (entrylo0),
        .entrylo1_i    (entrylo1),
        .wired_we_i    (wired_we),
        .wired_i       (wired_in),
        .done_o        (done),
        .rd_entryhi_o  (rd_hi),
        .rd_entrylo0_o (rd_lo0),
        .rd_entrylo1_o (rd_lo1),
        .probe_miss_o  (probe_miss),
        .probe_index_o (probe_index),
        .mcheck_o      (mcheck),
        .random_o      (random_v),
        .wired_o       (wired_v),
        .entries_o     (entries)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [18:0] m_vpn2 [N];
    logic [7:0]  m_asid [N];
    logic        m_g    [N];
    logic [31:0] m_lo0  [N];
    logic [31:0] m_lo1  [N];
    logic [31:0] last_hi, last_lo0, last_lo1;
    logic        last_miss, last_mc;
    logic [3:0]  last_pidx;
    int          mcnt = 0;
    int          mwired = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        int             cyc_done;
        logic [N*W-1:0] ents;
        logic [31:0]    hi, lo0, lo1;
        logic           miss, mc;
        logic [3:0]     pidx;
    } exp_t;
    exp_t exp_q[$];

    // Random is 15 minus the cycles since the last reload, modulo the window size 16-Wired.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            mcnt   <= 0;
            mwired <= 0;
        end else if (wired_we) begin
            mcnt   <= 0;
            mwired <= int'(wired_in);
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    function automatic int exp_random();
        return 15 - (mcnt % (16 - mwired));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_lo0[i] = '0; m_lo1[i] = '0;
        end
        last_hi = '0; last_lo0 = '0; last_lo1 = '0;
        last_miss = 1'b0; last_mc = 1'b0; last_pidx = '0;
    endfunction

    function automatic logic [N*W-1:0] model_entries();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*W +: 19]      = m_vpn2[i];
            v[i*W + 24 +: 8]  = m_asid[i];
            v[i*W + 32 +: 20] = m_lo0[i][25:6];
            v[i*W + 58 +: 3]  = m_lo0[i][5:3];
            v[i*W + 61]       = m_lo0[i][2];
            v[i*W + 62]       = m_lo0[i][1];
            v[i*W + 63]       = m_g[i];
            v[i*W + 64 +: 20] = m_lo1[i][25:6];
            v[i*W + 90 +: 3]  = m_lo1[i][5:3];
            v[i*W + 93]       = m_lo1[i][2];
            v[i*W + 94]       = m_lo1[i][1];
            v[i*W + 95]       = m_g[i];
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_entries(input string name, input logic [N*W-1:0] act,
                                 input logic [N*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < N; i++) begin
                if (act[i*W +: W] !== exp[i*W +: W]) begin
                    $display("FAIL %s: entry %0d got %h, expected %h", name, i,
                             act[i*W +: W], exp[i*W +: W]);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && mon_en) begin
            check("random", {28'd0, random_v}, exp_random());
            check("wired", {28'd0, wired_v}, mwired);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done: unexpected completion, got 1, expected 0 (cycle %0d)",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc_done);
                    check_entries("entries", entries, e.ents);
                    check("rd_entryhi", rd_hi, e.hi);
                    check("rd_entrylo0", rd_lo0, e.lo0);
                    check("rd_entrylo1", rd_lo1, e.lo1);
                    check("probe_miss", {31'd0, probe_miss}, {31'd0, e.miss});
                    check("probe_index", {28'd0, probe_index}, {28'd0, e.pidx});
                    check("mcheck", {31'd0, mcheck}, {31'd0, e.mc});
                end
            end
        end
    end

    // Issue one op at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic do_op(input int op, input logic [3:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1, input int inj_wired);
        exp_t e;
        int   tgt;
        int   hits;
        bit   done_seen;
        tgt = (op == 2) ? exp_random() : int'(idx);
        case (op)
            0: begin
                last_hi  = {m_vpn2[tgt], 5'd0, m_asid[tgt]};
                last_lo0 = {6'd0, m_lo0[tgt][25:1], m_g[tgt]};
                last_lo1 = {6'd0, m_lo1[tgt][25:1], m_g[tgt]};
            end
            1, 2: begin
                m_vpn2[tgt] = hi[31:13];
                m_asid[tgt] = hi[7:0];
                m_g[tgt]    = lo0[0] & lo1[0];
                m_lo0[tgt]  = lo0;
                m_lo1[tgt]  = lo1;
            end
            default: begin
                hits = 0;
                last_pidx = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_vpn2[i] == hi[31:13] && (m_asid[i] == hi[7:0] || m_g[i])) begin
                        hits++;
                        last_pidx = 4'(i);
                    end
                end
                last_miss = (hits == 0);
`ifdef TLB_MCHECK_EN
                last_mc = (hits > 1);
`else
                last_mc = 1'b0;
`endif
            end
        endcase
        e.cyc_done = cyc + ((op == 3) ? 3 : 2);
        e.ents = model_entries();
        e.hi = last_hi; e.lo0 = last_lo0; e.lo1 = last_lo1;
        e.miss = last_miss; e.pidx = last_pidx; e.mc = last_mc;
        exp_q.push_back(e);

        req_valid = 1'b1; req_op = 2'(op); index = idx;
        entryhi = hi; entrylo0 = lo0; entrylo1 = lo1;
        @(negedge clk);
        // Operands are latched at the handshake; scramble them to prove it.
        req_valid = 1'b0; index = 4'($urandom);
        entryhi = $urandom; entrylo0 = $urandom; entrylo1 = $urandom;
        if (inj_wired >= 0) begin
            wired_we = 1'b1;
            wired_in = 4'(inj_wired);
        end
        done_seen = 1'b0;
        for (int k = 0; k < 8 && !done_seen; k++) begin
            check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                @(negedge clk);
                wired_we = 1'b0;
            end
        end
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done for op %0d", op);
        end
        @(negedge clk);
        wired_we = 1'b0;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic set_wired(input logic [3:0] v);
        wired_we = 1'b1;
        wired_in = v;
        @(negedge clk);
        wired_we = 1'b0;
    endtask

    initial begin
        logic [18:0] vp;
        logic [31:0] hi;
        int          op;
        int          inj;

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; index = '0;
        entryhi = '0; entrylo0 = '0; entrylo1 = '0; wired_we = 1'b0; wired_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_random", {28'd0, random_v}, 32'd15);
        check("reset_wired", {28'd0, wired_v}, 32'd0);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd_hi", rd_hi, 32'd0);
        check("reset_miss", {31'd0, probe_miss}, 32'd0);
        check("reset_pidx", {28'd0, probe_index}, 32'd0);
        check("reset_mcheck", {31'd0, mcheck}, 32'd0);
        check_entries("reset_entries", entries, '0);
        mon_en = 1'b1;
        repeat (17) @(negedge clk);

        // Write then read back entry 5
        do_op(1, 4'd5, 32'h0040_2003, 32'h0000_1047, 32'h0000_1087, -1);
        check("entry5_vpn2", {13'd0, entries[5*W +: 19]}, 32'h201);
        do_op(0, 4'd5, $urandom, $urandom, $urandom, -1);
        check("tlbr_hi", rd_hi, 32'h0040_2003);
        check("tlbr_lo0", rd_lo0, 32'h0000_1047);

        // Probe hit on two entries, then a miss
        do_op(1, 4'd2, 32'h0040_2003, 32'h0000_2047, 32'h0000_2087, -1);
        do_op(1, 4'd9, 32'h0040_2003, 32'h0000_3047, 32'h0000_3087, -1);
        do_op(3, 4'd7, 32'h0040_2003, $urandom, $urandom, -1);
        check("probe_hit_idx", {28'd0, probe_index}, 32'd2);
        do_op(3, 4'd7, 32'h0060_0003, $urandom, $urandom, -1);
        check("probe_miss_flag", {31'd0, probe_miss}, 32'd1);

        // ASID mismatch with G clear, then with G set
        do_op(1, 4'd7, {19'h155, 5'd0, 8'h03}, 32'h0000_1046, 32'h0000_1087, -1);
        do_op(3, 4'd0, {19'h155, 5'd0, 8'h04}, $urandom, $urandom, -1);
        do_op(1, 4'd7, {19'h155, 5'd0, 8'h03}, 32'h0000_1047, 32'h0000_1087, -1);
        do_op(3, 4'd0, {19'h155, 5'd0, 8'h04}, $urandom, $urandom, -1);

        // Wired=12 window, TLBWR at Random=13 with a Wired write while in flight
        set_wired(4'd12);
        for (int k = 0; k < 20 && exp_random() != 13; k++) @(negedge clk);
        check("wait_random13", {28'd0, random_v}, 32'd13);
        do_op(2, 4'd0, {19'h3AB, 5'd0, 8'h11}, 32'h0000_5047, 32'h0000_5086, 0);
        check("tlbwr_entry13", {13'd0, entries[13*W +: 19]}, 32'h3AB);

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) set_wired(4'($urandom_range(0, 15)));
            case ($urandom_range(0, 3))
                0:       vp = 19'h201;
                1:       vp = 19'h155;
                2:       vp = 19'h300;
                default: vp = 19'h7ABCD;
            endcase
            hi  = {vp, 5'($urandom), ($urandom_range(0, 1) == 1) ? 8'h03 : 8'h04};
            op  = $urandom_range(0, 3);
            inj = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1;
            do_op(op, 4'($urandom), hi, $urandom, $urandom, inj);
        end

        // Reset during PROBE1
        req_valid = 1'b1; req_op = 2'd3; entryhi = 32'h0040_2003;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        check_entries("midrst_entries", entries, '0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_op(1, 4'd3, 32'h0040_2003, 32'h0000_1047, 32'h0000_1087, -1);
        do_op(0, 4'd3, $urandom, $urandom, $urandom, -1);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
